// File: rtl/sdrd_byte_collector.sv
// sdrd_byte_collector
// Collects the sequencer's serial SDRD read data into bytes (LSB first),
// queues them in a small FIFO and presents data/status to the host bus
// through the SSER/BA13/BA12 decode window.
// Optional feature macro: SDRD_PARITY_EN
//   defined   -> 9-bit frames, bit 8 must equal the XOR of bits 0..7,
//                a mismatch drops the byte and sets the sticky PERR flag
//   undefined -> 8-bit frames, PERR reads as 0
module sdrd_byte_collector #(
  parameter int         DEPTH    = 4,
  parameter logic [3:0] DATA_NIB = 4'h0,
  parameter logic [3:0] STAT_NIB = 4'h1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SSER,
  input  logic       BA13,
  input  logic       BA12,
  input  logic [3:0] BA7_4,
  input  logic       BR_W,
  input  logic       SDRD,
  input  logic       SDRD_EN,
  output logic [7:0] BD,
  output logic       BD_OE,
  output logic       RDY
);

  localparam int AW = $clog2(DEPTH);

`ifdef SDRD_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  localparam logic [3:0]  LAST_CNT = 4'(FRAME - 1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  // Deserializer state
  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [FRAME-1:0] shift_q, shift_d;
  logic [FRAME-1:0] frame_w;
  logic             frame_done;
  logic             ferr_evt;
  logic             push_req;

  // FIFO state
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full;
  logic          push;
  logic          pop;
  logic          ovr_evt;

  // Bus decode and access-edge tracking
  logic bus_win;
  logic data_sel;
  logic stat_sel;
  logic data_hit_q, data_hit_d;
  logic stat_hit_q, stat_hit_d;
  logic stat_clr;

  // Sticky error flags
  logic ovr_q, ovr_d;
  logic ferr_q, ferr_d;
  logic perr;

  logic       rdy;
  logic [7:0] head;
  logic [7:0] status;

  // Address decode: data select takes priority if both nibbles match
  always_comb begin
    bus_win  = ~SSER & ~BA13 & BA12 & BR_W;
    data_sel = bus_win & (BA7_4 == DATA_NIB);
    stat_sel = bus_win & (BA7_4 == STAT_NIB) & ~data_sel;
  end

  // Only the first cycle of a held access pops data or clears status
  always_comb begin
    data_hit_d = data_sel;
    stat_hit_d = stat_sel;
    pop        = data_sel & ~data_hit_q & (count_q != '0);
    stat_clr   = stat_sel & ~stat_hit_q;
  end

  // Current frame with this cycle's SDRD bit merged in at position cnt
  always_comb begin
    frame_w = shift_q;
    for (int i = 0; i < FRAME; i++) begin
      if (cnt_q == 4'(i)) begin
        frame_w[i] = SDRD;
      end
    end
  end

  // Deserializer next state: sample while SDRD_EN, flag frames cut short
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    frame_done = 1'b0;
    ferr_evt   = 1'b0;
    case (state_q)
      IDLE: begin
        if (SDRD_EN) begin
          shift_d = {{(FRAME-1){1'b0}}, SDRD};
          cnt_d   = 4'd1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (SDRD_EN) begin
          shift_d = frame_w;
          if (cnt_q == LAST_CNT) begin
            frame_done = 1'b1;
            cnt_d      = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          ferr_evt = (cnt_q != 4'd0);
          cnt_d    = 4'd0;
          state_d  = IDLE;
        end
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
    endcase
  end

`ifdef SDRD_PARITY_EN
  logic perr_q, perr_d;
  logic perr_evt;

  // Parity check on a completed frame; bad frames never reach the FIFO
  always_comb begin
    perr_evt = frame_done & (frame_w[8] != ^frame_w[7:0]);
    push_req = frame_done & ~perr_evt;
    perr_d   = (perr_q & ~stat_clr) | perr_evt;
    perr     = perr_q;
  end

  // Sticky parity error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end
`else
  // Without parity every completed frame is pushed
  always_comb begin
    push_req = frame_done;
    perr     = 1'b0;
  end
`endif

  // FIFO bookkeeping: a pop in the same cycle frees room for a push when full
  always_comb begin
    full     = (count_q == FULL_CNT);
    push     = push_req & (~full | pop);
    ovr_evt  = push_req & full & ~pop;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = frame_w[7:0];
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Sticky flags: a new event in the clearing cycle keeps the flag set
  always_comb begin
    ovr_d  = (ovr_q & ~stat_clr) | ovr_evt;
    ferr_d = (ferr_q & ~stat_clr) | ferr_evt;
  end

  // All state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= '0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_hit_q <= 1'b0;
      stat_hit_q <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_hit_q <= data_hit_d;
      stat_hit_q <= stat_hit_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
    end
  end

  // Bus read mux, zero-latency from the address inputs
  always_comb begin
    rdy    = (count_q != '0);
    head   = rdy ? mem_q[rd_ptr_q] : 8'h00;
    status = {4'b0000, perr, ferr_q, ovr_q, rdy};
    BD_OE  = data_sel | stat_sel;
    RDY    = rdy;
    if (data_sel) begin
      BD = head;
    end else if (stat_sel) begin
      BD = status;
    end else begin
      BD = 8'h00;
    end
  end

endmodule

// File: tb/tb_sdrd_byte_collector.sv
// Self-checking bench for sdrd_byte_collector.
// Honours SDRD_PARITY_EN the same way as the design (9-bit frames when defined).
module tb_sdrd_byte_collector;

  localparam int         DEPTH    = 4;
  localparam logic [3:0] DATA_NIB = 4'h0;
  localparam logic [3:0] STAT_NIB = 4'h1;

`ifdef SDRD_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SSER = 1'b1;
  logic       BA13 = 1'b0;
  logic       BA12 = 1'b1;
  logic [3:0] BA7_4 = 4'h0;
  logic       BR_W = 1'b1;
  logic       SDRD = 1'b0;
  logic       SDRD_EN = 1'b0;
  logic [7:0] BD;
  logic       BD_OE;
  logic       RDY;

  int checkCount = 0;
  int passCount  = 0;

  sdrd_byte_collector #(
    .DEPTH   (DEPTH),
    .DATA_NIB(DATA_NIB),
    .STAT_NIB(STAT_NIB)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .SSER   (SSER),
    .BA13   (BA13),
    .BA12   (BA12),
    .BA7_4  (BA7_4),
    .BR_W   (BR_W),
    .SDRD   (SDRD),
    .SDRD_EN(SDRD_EN),
    .BD     (BD),
    .BD_OE  (BD_OE),
    .RDY    (RDY)
  );

  always #5 clk = ~clk;

  // Single comparison point for both the model checks and literal checks
  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit dataSel();
    return !SSER && !BA13 && BA12 && BR_W && (BA7_4 == DATA_NIB);
  endfunction

  function automatic bit statSel();
    return !SSER && !BA13 && BA12 && BR_W && (BA7_4 == STAT_NIB) && !dataSel();
  endfunction

  // Behavioural model: collected bits, byte queue and sticky flags
  logic [7:0] mFifo[$];
  bit         mBits[$];
  bit         mOvr, mFerr, mPerr;
  bit         prevData, prevStat;

  always @(posedge clk or negedge rst_n) begin
    bit         doPop, doClr, evOvr, evFerr, evPerr;
    logic [7:0] byteV;
    if (!rst_n) begin
      mFifo.delete();
      mBits.delete();
      mOvr     = 1'b0;
      mFerr    = 1'b0;
      mPerr    = 1'b0;
      prevData = 1'b0;
      prevStat = 1'b0;
    end else begin
      doPop  = dataSel() && !prevData;
      doClr  = statSel() && !prevStat;
      evOvr  = 1'b0;
      evFerr = 1'b0;
      evPerr = 1'b0;
      if (doPop && mFifo.size() > 0) begin
        void'(mFifo.pop_front());
      end
      if (SDRD_EN) begin
        mBits.push_back(SDRD);
        if (mBits.size() == FRAME) begin
          for (int i = 0; i < 8; i++) byteV[i] = mBits[i];
`ifdef SDRD_PARITY_EN
          evPerr = (mBits[8] != ^byteV);
`endif
          if (!evPerr) begin
            if (mFifo.size() < DEPTH) mFifo.push_back(byteV);
            else evOvr = 1'b1;
          end
          mBits.delete();
        end
      end else if (mBits.size() != 0) begin
        evFerr = 1'b1;
        mBits.delete();
      end
      mOvr     = (mOvr && !doClr) || evOvr;
      mFerr    = (mFerr && !doClr) || evFerr;
      mPerr    = (mPerr && !doClr) || evPerr;
      prevData = dataSel();
      prevStat = statSel();
    end
  end

  // Compare DUT outputs against the model every cycle, away from the active edge
  always @(negedge clk) begin
    logic [7:0] expBd;
    logic       expRdy;
    expRdy = (mFifo.size() != 0);
    if (dataSel()) expBd = expRdy ? mFifo[0] : 8'h00;
    else if (statSel()) expBd = {4'b0000, mPerr, mFerr, mOvr, expRdy};
    else expBd = 8'h00;
    checkOutput("model_bd_oe", {7'b0, BD_OE}, {7'b0, dataSel() || statSel()});
    checkOutput("model_rdy", {7'b0, RDY}, {7'b0, expRdy});
    checkOutput("model_bd", BD, expBd);
  end

  // Drive one cycle of inputs just after the active edge, then let them settle
  task automatic applyStimulus(input logic en, input logic b, input logic rd, input logic [3:0] nib);
    @(posedge clk);
    #1;
    SDRD_EN = en;
    SDRD    = b;
    SSER    = ~rd;
    BA7_4   = nib;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, DATA_NIB);
  endtask

  // Send one frame LSB first; optionally start a data read on its last bit
  task automatic sendFrame(input logic [7:0] b, input logic p, input bit readLast);
    logic [8:0] fr;
    fr = {p, b};
    for (int i = 0; i < FRAME; i++) begin
      applyStimulus(1'b1, fr[i], readLast && (i == FRAME - 1), DATA_NIB);
    end
  endtask

  task automatic readReg(input logic [3:0] nib, input string name, input logic [7:0] exp);
    applyStimulus(1'b0, 1'b0, 1'b1, nib);
    checkOutput(name, BD, exp);
    idleCycle();
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_rdy", {7'b0, RDY}, 8'h00);
    checkOutput("reset_bd", BD, 8'h00);
    checkOutput("reset_bd_oe", {7'b0, BD_OE}, 8'h00);
    rst_n = 1'b1;

    // Status read straight after reset
    applyStimulus(1'b0, 1'b0, 1'b1, STAT_NIB);
    checkOutput("stat_oe", {7'b0, BD_OE}, 8'h01);
    checkOutput("stat_reset", BD, 8'h00);
    idleCycle();

    // Single byte A5, visible the cycle after its last bit
    sendFrame(8'hA5, ^8'hA5, 1'b0);
    idleCycle();
    checkOutput("a5_rdy", {7'b0, RDY}, 8'h01);
    readReg(DATA_NIB, "a5_data", 8'hA5);
    checkOutput("a5_rdy_after_pop", {7'b0, RDY}, 8'h00);

    // Five bytes into a four-entry FIFO
    for (int k = 1; k <= 5; k++) sendFrame(8'(k), ^8'(k), 1'b0);
    idleCycle();
    readReg(STAT_NIB, "ovr_status", 8'h03);
    for (int k = 1; k <= 4; k++) readReg(DATA_NIB, "ovr_data", 8'(k));
    readReg(STAT_NIB, "ovr_status_clear", 8'h00);

    // Short frame sets FERR and pushes nothing
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, DATA_NIB);
    idleCycle();
    readReg(STAT_NIB, "ferr_status", 8'h04);

    // Held data read pops only once
    sendFrame(8'h5A, ^8'h5A, 1'b0);
    sendFrame(8'hC3, ^8'hC3, 1'b0);
    sendFrame(8'h99, ^8'h99, 1'b0);
    idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, DATA_NIB);
    checkOutput("held_first", BD, 8'h5A);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, DATA_NIB);
    checkOutput("held_next_head", BD, 8'hC3);
    idleCycle();
    readReg(DATA_NIB, "held_second", 8'hC3);

    // Push into a full FIFO on the same cycle as a pop succeeds
    sendFrame(8'h11, ^8'h11, 1'b0);
    sendFrame(8'h22, ^8'h22, 1'b0);
    sendFrame(8'h33, ^8'h33, 1'b0);
    sendFrame(8'h44, ^8'h44, 1'b1);
    idleCycle();
    readReg(STAT_NIB, "full_pop_push_status", 8'h01);
    readReg(DATA_NIB, "full_pop_push_head", 8'h11);

    // Reset in the middle of a frame
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, DATA_NIB);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_rdy", {7'b0, RDY}, 8'h00);
    idleCycle();
    rst_n = 1'b1;
    sendFrame(8'h3C, ^8'h3C, 1'b0);
    idleCycle();
    readReg(STAT_NIB, "after_reset_status", 8'h01);
    readReg(DATA_NIB, "after_reset_data", 8'h3C);
    readReg(STAT_NIB, "after_reset_empty", 8'h00);

`ifdef SDRD_PARITY_EN
    // Bad then good parity on 8'h07
    sendFrame(8'h07, 1'b0, 1'b0);
    idleCycle();
    readReg(STAT_NIB, "perr_status", 8'h08);
    sendFrame(8'h07, 1'b1, 1'b0);
    idleCycle();
    readReg(DATA_NIB, "parity_ok_data", 8'h07);
`endif

    idleCycle();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
